fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/fetch_wdog.sv | 36 +++
 rtl/fetch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/decode control slice: controller state
// encoding, instruction class encoding, opcode constants and the opcode
// classifier.
// Optional feature macro: JALR_EN (when defined, opcode 1100111 is a legal JALR).
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_BR   = 2'd1,
        CLS_JAL  = 2'd2,
        CLS_JALR = 2'd3
    } iclass_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic    legal;
        iclass_t cls;
    } decode_t;

    // Map an opcode to its control class; unknown opcodes come back illegal
    // with the class parked at ALU so nothing downstream sees a stray class.
    function automatic decode_t decode_opcode(input logic [6:0] op);
        decode_t d;
        d.legal = 1'b0;
        d.cls   = CLS_ALU;
        case (op)
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC: begin
                d.legal = 1'b1;
                d.cls   = CLS_ALU;
            end
            OP_BRANCH: begin
                d.legal = 1'b1;
                d.cls   = CLS_BR;
            end
            OP_JAL: begin
                d.legal = 1'b1;
                d.cls   = CLS_JAL;
            end
`ifdef JALR_EN
            OP_JALR: begin
                d.legal = 1'b1;
                d.cls   = CLS_JALR;
            end
`endif
            default: begin
                d.legal = 1'b0;
                d.cls   = CLS_ALU;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fetch_wdog.sv
// FETCH wait watchdog: counts cycles spent waiting for the instruction
// memory and flags when the count reaches MAX_WAIT. The count saturates at
// the limit so expired stays high until cleared.
module fetch_wdog #(
    parameter int MAX_WAIT = 15,
    parameter int WIDTH    = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(MAX_WAIT);

    logic [WIDTH-1:0] count_r;
    logic             expired_s;

    assign expired_s = (count_r == LIMIT_C);
    assign expired   = expired_s;

    // Wait counter: reset/clear to zero, count while enabled, hold at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (enable && !expired_s) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Multi-cycle instruction sequencing controller: FETCH -> DECODE -> EXEC ->
// WB, with HALT on request and a terminal FAULT on fetch timeout or an
// illegal opcode. Outputs decode the registered state (ir_load additionally
// follows imem_ack while fetching, and the branch strobe follows brcond in WB).
// Optional feature macro: JALR_EN (enables the JALR class and pc_jmplr).
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int n        = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       imem_ack,
    input  logic [6:0] opcode,
    input  logic       brcond,
    input  logic       halt_req,
    output logic       imem_req,
    output logic       ir_load,
    output logic       pc_incr,
    output logic       pc_brnch,
    output logic       pc_jmp,
    output logic       pc_jmplr,
    output logic       rf_we,
    output logic       fault,
    output logic [2:0] state
);

    if (n < 1 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_param_check
        $error("fetch_ctrl: n must be >= 1 and MAX_WAIT must be in 1..255");
    end

    state_t  state_r;
    state_t  state_next_s;
    iclass_t cls_r;
    iclass_t cls_next_s;
    decode_t dec_s;
    logic    wdog_clear_s;
    logic    wdog_enable_s;
    logic    wdog_expired_s;

    assign dec_s = decode_opcode(opcode);

    // The wait count only matters in FETCH; holding it clear elsewhere means
    // every fetch starts its timeout window from zero.
    assign wdog_clear_s  = (state_r != ST_FETCH) || imem_ack;
    assign wdog_enable_s = (state_r == ST_FETCH) && !imem_ack;

    fetch_wdog #(
        .MAX_WAIT (MAX_WAIT),
        .WIDTH    (8)
    ) u_wdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wdog_clear_s),
        .enable  (wdog_enable_s),
        .expired (wdog_expired_s)
    );

    // State and instruction-class registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FETCH;
            cls_r   <= CLS_ALU;
        end else begin
            state_r <= state_next_s;
            cls_r   <= cls_next_s;
        end
    end

    // Next-state logic; the class is captured only on a legal DECODE.
    always_comb begin
        state_next_s = state_r;
        cls_next_s   = cls_r;
        case (state_r)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_next_s = ST_DECODE;
                end else if (wdog_expired_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_s.legal) begin
                    state_next_s = ST_EXEC;
                    cls_next_s   = dec_s.cls;
                end else begin
                    state_next_s = ST_FAULT;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_WB;
            end
            ST_WB: begin
                if (halt_req) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (halt_req) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_FAULT: begin
                state_next_s = ST_FAULT;
            end
            default: begin
                state_next_s = ST_FAULT;
            end
        endcase
    end

    // Output decode; reset suppresses every load/write/PC strobe so an
    // interrupted instruction never commits anything.
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        pc_incr  = 1'b0;
        pc_brnch = 1'b0;
        pc_jmp   = 1'b0;
        rf_we    = 1'b0;
`ifdef JALR_EN
        pc_jmplr = 1'b0;
`endif
        case (state_r)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (reset) begin
                    ir_load = 1'b0;
                end else begin
                    ir_load = imem_ack;
                end
            end
            ST_WB: begin
                if (reset) begin
                    rf_we = 1'b0;
                end else begin
                    case (cls_r)
                        CLS_ALU: begin
                            pc_incr = 1'b1;
                            rf_we   = 1'b1;
                        end
                        CLS_BR: begin
                            if (brcond) begin
                                pc_brnch = 1'b1;
                            end else begin
                                pc_incr = 1'b1;
                            end
                        end
                        CLS_JAL: begin
                            pc_jmp = 1'b1;
                            rf_we  = 1'b1;
                        end
`ifdef JALR_EN
                        CLS_JALR: begin
                            pc_jmplr = 1'b1;
                            rf_we    = 1'b1;
                        end
`endif
                        default: begin
                            rf_we = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

`ifndef JALR_EN
    assign pc_jmplr = 1'b0;
`endif

    assign fault = (state_r == ST_FAULT);
    assign state = state_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl (built with MAX_WAIT=3). A vector
// table drives one row per cycle; each row's expected state and outputs go
// into a scoreboard queue when driven and are compared on the falling edge.
module tb_fetch_ctrl;
    import riscv_pkg::*;

    localparam logic [6:0] T_REG    = 7'b0110011;
    localparam logic [6:0] T_IMM    = 7'b0010011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_ILL    = 7'b0000000;

    // Output vector: {imem_req, ir_load, pc_incr, pc_brnch, pc_jmp, pc_jmplr, rf_we, fault}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_REQ  = 8'b1000_0000;
    localparam logic [7:0] O_LD   = 8'b0100_0000;
    localparam logic [7:0] O_INC  = 8'b0010_0000;
    localparam logic [7:0] O_BR   = 8'b0001_0000;
    localparam logic [7:0] O_JMP  = 8'b0000_1000;
    localparam logic [7:0] O_JR   = 8'b0000_0100;
    localparam logic [7:0] O_WE   = 8'b0000_0010;
    localparam logic [7:0] O_FLT  = 8'b0000_0001;

    typedef struct {
        logic       rst;
        logic       ack;
        logic [6:0] op;
        logic       br;
        logic       halt;
        logic [2:0] st;
        logic [7:0] out;
        int         idx;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       imem_ack;
    logic [6:0] opcode;
    logic       brcond;
    logic       halt_req;
    logic       imem_req;
    logic       ir_load;
    logic       pc_incr;
    logic       pc_brnch;
    logic       pc_jmp;
    logic       pc_jmplr;
    logic       rf_we;
    logic       fault;
    logic [2:0] state;

    vec_t tbl[$];
    vec_t exp_q[$];
    vec_t cur_e;
    int   checks;
    int   failures;
    int   row_no;
    logic [7:0] act_out;

    fetch_ctrl #(
        .n        (32),
        .MAX_WAIT (3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .imem_ack (imem_ack),
        .opcode   (opcode),
        .brcond   (brcond),
        .halt_req (halt_req),
        .imem_req (imem_req),
        .ir_load  (ir_load),
        .pc_incr  (pc_incr),
        .pc_brnch (pc_brnch),
        .pc_jmp   (pc_jmp),
        .pc_jmplr (pc_jmplr),
        .rf_we    (rf_we),
        .fault    (fault),
        .state    (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic rst, input logic ack, input logic [6:0] op,
                       input logic br, input logic halt,
                       input state_t st, input logic [7:0] out);
        vec_t v;
        v.rst  = rst;
        v.ack  = ack;
        v.op   = op;
        v.br   = br;
        v.halt = halt;
        v.st   = st;
        v.out  = out;
        v.idx  = tbl.size();
        tbl.push_back(v);
    endtask

    // Drive one row just after the rising edge and queue its expectation.
    task automatic drive(input vec_t v);
        @(posedge clock);
        #1;
        reset    = v.rst;
        imem_ack = v.ack;
        opcode   = v.op;
        brcond   = v.br;
        halt_req = v.halt;
        exp_q.push_back(v);
    endtask

    task automatic step(input logic rst, input logic ack, input logic [6:0] op,
                        input logic br, input logic halt,
                        input state_t st, input logic [7:0] out);
        vec_t v;
        v.rst  = rst;
        v.ack  = ack;
        v.op   = op;
        v.br   = br;
        v.halt = halt;
        v.st   = st;
        v.out  = out;
        v.idx  = 1000 + row_no;
        row_no = row_no + 1;
        drive(v);
    endtask

    // Scoreboard: compare each queued expectation mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            cur_e   = exp_q.pop_front();
            act_out = {imem_req, ir_load, pc_incr, pc_brnch, pc_jmp, pc_jmplr, rf_we, fault};
            checks  = checks + 1;
            if (state !== cur_e.st) begin
                failures = failures + 1;
                $display("FAIL state row=%0d actual=%0d required=%0d", cur_e.idx, state, cur_e.st);
            end
            checks = checks + 1;
            if (act_out !== cur_e.out) begin
                failures = failures + 1;
                $display("FAIL outputs row=%0d actual=%b required=%b", cur_e.idx, act_out, cur_e.out);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        row_no   = 0;
        reset    = 1'b1;
        imem_ack = 1'b0;
        opcode   = T_REG;
        brcond   = 1'b0;
        halt_req = 1'b0;

        // Reset with ack high: FETCH, imem_req only, no ir_load.
        add(1'b1, 1'b1, T_REG, 1'b0, 1'b0, ST_FETCH, O_REQ);
        // ALU: ir_load in cycle 1, pc_incr + rf_we in cycle 4.
        add(1'b0, 1'b1, T_REG, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        add(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_DECODE, O_NONE);
        add(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        add(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_WB,     O_INC | O_WE);
        // Branch taken; ack and halt outside FETCH/WB are ignored.
        add(1'b0, 1'b1, T_BRANCH, 1'b1, 1'b0, ST_FETCH,  O_REQ | O_LD);
        add(1'b0, 1'b1, T_BRANCH, 1'b1, 1'b1, ST_DECODE, O_NONE);
        add(1'b0, 1'b1, T_BRANCH, 1'b1, 1'b1, ST_EXEC,   O_NONE);
        add(1'b0, 1'b0, T_BRANCH, 1'b1, 1'b0, ST_WB,     O_BR);
        // Branch not taken.
        add(1'b0, 1'b1, T_BRANCH, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        add(1'b0, 1'b0, T_BRANCH, 1'b0, 1'b0, ST_DECODE, O_NONE);
        add(1'b0, 1'b0, T_BRANCH, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        add(1'b0, 1'b0, T_BRANCH, 1'b0, 1'b0, ST_WB,     O_INC);
        // JAL with one wait cycle, then halt from WB.
        add(1'b0, 1'b0, T_JAL, 1'b0, 1'b0, ST_FETCH,  O_REQ);
        add(1'b0, 1'b1, T_JAL, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        add(1'b0, 1'b0, T_JAL, 1'b0, 1'b0, ST_DECODE, O_NONE);
        add(1'b0, 1'b0, T_JAL, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        add(1'b0, 1'b0, T_JAL, 1'b0, 1'b1, ST_WB,     O_JMP | O_WE);
        add(1'b0, 1'b1, T_JAL, 1'b0, 1'b1, ST_HALT,   O_NONE);
        add(1'b0, 1'b0, T_JAL, 1'b0, 1'b0, ST_HALT,   O_NONE);
        // Remaining ALU opcodes.
        add(1'b0, 1'b1, T_IMM, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        add(1'b0, 1'b0, T_IMM, 1'b0, 1'b0, ST_DECODE, O_NONE);
        add(1'b0, 1'b0, T_IMM, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        add(1'b0, 1'b0, T_IMM, 1'b0, 1'b0, ST_WB,     O_INC | O_WE);
        add(1'b0, 1'b1, T_LUI, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        add(1'b0, 1'b0, T_LUI, 1'b0, 1'b0, ST_DECODE, O_NONE);
        add(1'b0, 1'b0, T_LUI, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        add(1'b0, 1'b0, T_LUI, 1'b0, 1'b0, ST_WB,     O_INC | O_WE);
        add(1'b0, 1'b1, T_AUIPC, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        add(1'b0, 1'b0, T_AUIPC, 1'b0, 1'b0, ST_DECODE, O_NONE);
        add(1'b0, 1'b0, T_AUIPC, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        add(1'b0, 1'b0, T_AUIPC, 1'b0, 1'b0, ST_WB,     O_INC | O_WE);
        // JALR: legal only with the feature enabled.
        add(1'b0, 1'b1, T_JALR, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        add(1'b0, 1'b0, T_JALR, 1'b0, 1'b0, ST_DECODE, O_NONE);
`ifdef JALR_EN
        add(1'b0, 1'b0, T_JALR, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        add(1'b0, 1'b0, T_JALR, 1'b0, 1'b0, ST_WB,     O_JR | O_WE);
        add(1'b0, 1'b1, T_ILL,  1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        add(1'b0, 1'b0, T_ILL,  1'b0, 1'b0, ST_DECODE, O_NONE);
`endif
        add(1'b0, 1'b1, T_REG, 1'b0, 1'b0, ST_FAULT, O_FLT);
        add(1'b0, 1'b0, T_REG, 1'b0, 1'b1, ST_FAULT, O_FLT);
        // Reset out of FAULT.
        add(1'b1, 1'b0, T_REG, 1'b0, 1'b0, ST_FAULT, O_FLT);
        add(1'b1, 1'b0, T_REG, 1'b0, 1'b0, ST_FETCH, O_REQ);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
        end

        // Illegal opcode 0000000 faults from DECODE (state is FETCH under reset).
        step(1'b0, 1'b1, T_ILL, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        step(1'b0, 1'b0, T_ILL, 1'b0, 1'b0, ST_DECODE, O_NONE);
        step(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_FAULT,  O_FLT);
        step(1'b1, 1'b0, T_REG, 1'b0, 1'b0, ST_FAULT,  O_FLT);

        // Timeout with MAX_WAIT=3: four FETCH cycles, then sticky FAULT.
        step(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_FETCH, O_REQ);
        step(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_FETCH, O_REQ);
        step(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_FETCH, O_REQ);
        step(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_FETCH, O_REQ);
        step(1'b0, 1'b1, T_REG, 1'b0, 1'b0, ST_FAULT, O_FLT);
        step(1'b0, 1'b1, T_REG, 1'b0, 1'b0, ST_FAULT, O_FLT);
        step(1'b1, 1'b0, T_REG, 1'b0, 1'b0, ST_FAULT, O_FLT);

        // Reset in EXEC: no strobes, FETCH with imem_req after release.
        step(1'b0, 1'b1, T_REG, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        step(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_DECODE, O_NONE);
        step(1'b1, 1'b0, T_REG, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        step(1'b0, 1'b1, T_REG, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        step(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_DECODE, O_NONE);
        step(1'b0, 1'b0, T_REG, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        // Reset in WB suppresses pc_incr and rf_we.
        step(1'b1, 1'b0, T_REG, 1'b0, 1'b0, ST_WB,     O_NONE);
        step(1'b0, 1'b1, T_BRANCH, 1'b0, 1'b0, ST_FETCH,  O_REQ | O_LD);
        step(1'b0, 1'b0, T_BRANCH, 1'b0, 1'b0, ST_DECODE, O_NONE);
        step(1'b0, 1'b0, T_BRANCH, 1'b0, 1'b0, ST_EXEC,   O_NONE);
        step(1'b0, 1'b0, T_BRANCH, 1'b0, 1'b1, ST_WB,     O_INC);
        // Reset in HALT overrides a held halt_req.
        step(1'b1, 1'b0, T_REG, 1'b0, 1'b1, ST_HALT,  O_NONE);
        step(1'b0, 1'b0, T_REG, 1'b0, 1'b1, ST_FETCH, O_REQ);

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) begin
            @(posedge clock);
        end
        @(posedge clock);
        if (exp_q.size() > 0) begin
            failures = failures + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
